// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam logic       CTRL_PASS   = 1'b1;
  localparam logic       CTRL_BUBBLE = 1'b0;

  // r0 is hardwired to zero, so a load targeting it can never create a dependency.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt);
    return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller beside the ID stage: memory-wait freeze, branch flush and
// load-use stall arbitration with zero-latency (Mealy) enables.
//
//   state    | meaning
//   RUN      | normal flow, load-use detection active
//   LU_STALL | inserting remaining load-use bubbles (lu_cnt left)
//   MEM_WAIT | data memory not ready; pipeline frozen, prior state saved
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 64,
  parameter int STALL_CNT_W     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   IDEX_MemRead_i,
  input  logic [4:0]             IDEX_Rt_i,
  input  logic [4:0]             IFID_Rs_i,
  input  logic [4:0]             IFID_Rt_i,
  input  logic                   branch_taken_i,
  input  logic                   mem_access_i,
  input  logic                   dmem_ready_i,
  output logic                   ctrl_sel_o,
  output logic                   pc_write_o,
  output logic                   ifid_write_o,
  output logic                   ifid_flush_o,
  output logic                   exmem_flush_o,
  output logic                   pipe_hold_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   mem_timeout_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e         state;
  hz_state_e         state_next;
  hz_state_e         saved_state;
  hz_state_e         eff_state;
  logic [1:0]        lu_cnt;
  logic [1:0]        lu_cnt_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              lu_hit;

  assign freeze    = mem_access_i & ~dmem_ready_i;
  assign lu_hit    = load_use_hit(IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i);
  // While frozen, decisions resume from the state that was interrupted.
  assign eff_state = (state == MEM_WAIT) ? saved_state : state;

  always_comb begin
    ctrl_sel_o    = CTRL_PASS;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    pipe_hold_o   = 1'b0;
    state_next    = RUN;
    lu_cnt_next   = lu_cnt;

    if (freeze) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      pipe_hold_o  = 1'b1;
      state_next   = MEM_WAIT;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      ctrl_sel_o    = CTRL_BUBBLE;
      lu_cnt_next   = 2'd0;
    end else if (eff_state == LU_STALL) begin
      ctrl_sel_o   = CTRL_BUBBLE;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      if (lu_cnt <= 2'd1) begin
        lu_cnt_next = 2'd0;
      end else begin
        lu_cnt_next = lu_cnt - 1'b1;
        state_next  = LU_STALL;
      end
    end else if (lu_hit) begin
      ctrl_sel_o   = CTRL_BUBBLE;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      if (LOAD_USE_CYCLES > 1) begin
        lu_cnt_next = 2'(LOAD_USE_CYCLES - 1);
        state_next  = LU_STALL;
      end else begin
        lu_cnt_next = 2'd0;
      end
    end else begin
      lu_cnt_next = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= RUN;
      saved_state   <= RUN;
      lu_cnt        <= 2'd0;
      wait_cnt      <= '0;
      mem_timeout_o <= 1'b0;
    end else begin
      state  <= state_next;
      lu_cnt <= lu_cnt_next;
      if (freeze) begin
        saved_state <= eff_state;
        if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        // Flag on the edge where the count lands on MEM_TIMEOUT.
        if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
          mem_timeout_o <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .inc   (~pc_write_o),
    .clear (1'b0),
    .count (stall_cnt_o)
  );

endmodule
